// File: rtl/cr_kme_ser_pkg.sv
// rtl/cr_kme_ser_pkg.sv - shared widths, types and helpers for the KME key serializer
package cr_kme_ser_pkg;

    localparam int KME_KEY_W  = 256;
    localparam int KME_BEAT_W = 64;

    typedef logic [KME_BEAT_W-1:0] kme_beat_t;

    // Number of narrow beats needed to carry one wide word.
    function automatic int beats_of(input int data_w, input int beat_w);
        return data_w / beat_w;
    endfunction

endpackage

// File: rtl/cr_kme_fifo_serializer.sv
// rtl/cr_kme_fifo_serializer.sv - pops 256-bit KME key words and emits them as LSB-first narrow beats
module cr_kme_fifo_serializer
    import cr_kme_ser_pkg::*;
#(
    parameter int DATA_SIZE = KME_KEY_W,
    parameter int OUT_SIZE  = KME_BEAT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] fifo_out,
    input  logic                 fifo_out_valid,
    output logic                 fifo_out_ack,
    input  logic                 flush,
    output logic [OUT_SIZE-1:0]  out_data,
    output logic                 out_valid,
    output logic                 out_first,
    output logic                 out_last,
    input  logic                 out_stall,
    output logic [15:0]          words_done
);

    localparam int NUM_BEATS = beats_of(DATA_SIZE, OUT_SIZE);
    localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    logic [DATA_SIZE-1:0] buf_q;
    logic                 full_q;
    logic [IDX_W-1:0]     idx_q;
    logic [15:0]          words_done_q;

    logic acc;
    logic drain;
    logic load;
    logic at_last;

    // Handshake decode: a beat leaves when held and not stalled; refill on the last beat gives zero bubble.
    always_comb begin
        at_last      = (idx_q == LAST_IDX);
        acc          = full_q & ~out_stall;
        drain        = acc & at_last;
        load         = fifo_out_valid & (~full_q | drain) & ~flush & ~rst;
        fifo_out_ack = load;
        out_valid    = full_q;
        out_first    = full_q & (idx_q == '0);
        out_last     = full_q & at_last;
        out_data     = full_q ? buf_q[int'(idx_q) * OUT_SIZE +: OUT_SIZE] : '0;
        words_done   = words_done_q;
    end

    // Word buffer and beat index; flush drops the held word but leaves buf_q contents in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            full_q <= 1'b0;
            idx_q  <= '0;
        end else if (flush) begin
            full_q <= 1'b0;
            idx_q  <= '0;
        end else if (load) begin
            buf_q  <= fifo_out;
            full_q <= 1'b1;
            idx_q  <= '0;
        end else if (acc) begin
            if (at_last) begin
                full_q <= 1'b0;
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Completed-word counter; a last beat accepted alongside a flush still counts as delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_done_q <= '0;
        end else if (drain && (words_done_q != 16'hFFFF)) begin
            words_done_q <= words_done_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_serializer.sv
// tb/tb_cr_kme_fifo_serializer.sv - self-checking bench for cr_kme_fifo_serializer
module tb_cr_kme_fifo_serializer;
    import cr_kme_ser_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [KME_KEY_W-1:0] fifo_out;
    logic                 fifo_out_valid;
    logic                 fifo_out_ack;
    logic                 flush;
    kme_beat_t            out_data;
    logic                 out_valid;
    logic                 out_first;
    logic                 out_last;
    logic                 out_stall;
    logic [15:0]          words_done;

    cr_kme_fifo_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_out       (fifo_out),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ack   (fifo_out_ack),
        .flush          (flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_first      (out_first),
        .out_last       (out_last),
        .out_stall      (out_stall),
        .words_done     (words_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic      r;
        logic      f;
        logic      s;
        logic      ack;
        logic      valid;
        kme_beat_t data;
        logic      first;
        logic      last;
        logic [15:0] wd;
    } tvec_t;

    typedef struct {
        kme_beat_t data;
        bit        first;
        bit        last;
    } beat_t;

    tvec_t                tbl [7];
    tvec_t                tbl_cur;
    bit                   tbl_on = 0;
    beat_t                exp_q [$];
    logic [KME_KEY_W-1:0] fq [$];
    int                   exp_words = 0;
    int                   n_cmp = 0;
    int                   n_fail = 0;
    int                   ack_cnt = 0;
    int                   beat_cnt = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KME_KEY_W-1:0] mk_word(input kme_beat_t a, input kme_beat_t b,
                                                     input kme_beat_t c, input kme_beat_t d);
        return {d, c, b, a};
    endfunction

    function automatic logic [KME_KEY_W-1:0] rnd_word();
        logic [KME_KEY_W-1:0] w;
        for (int i = 0; i < KME_KEY_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock: drive inputs, check at the falling edge against the model, then advance the model.
    task automatic cyc(input logic r, input logic f, input logic s);
        bit m_valid, m_acc, m_drain, m_ack;
        logic [KME_KEY_W-1:0] w;
        rst = r;
        flush = f;
        out_stall = s;
        fifo_out_valid = (fq.size() != 0);
        fifo_out = (fq.size() != 0) ? fq[0] : '0;
        @(negedge clk);
        if (tbl_on) begin
            chk("tbl_ack", fifo_out_ack, tbl_cur.ack);
            chk("tbl_valid", out_valid, tbl_cur.valid);
            chk("tbl_data", out_data, tbl_cur.data);
            chk("tbl_first", out_first, tbl_cur.first);
            chk("tbl_last", out_last, tbl_cur.last);
            chk("tbl_words", words_done, tbl_cur.wd);
        end
        m_valid = (exp_q.size() != 0);
        m_acc   = m_valid && !s;
        m_drain = m_acc && exp_q[0].last;
        m_ack   = (fq.size() != 0) && (!m_valid || m_drain) && !f && !r;
        chk("ack", fifo_out_ack, m_ack);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_valid ? exp_q[0].data : '0);
        chk("out_first", out_first, m_valid && exp_q[0].first);
        chk("out_last", out_last, m_valid && exp_q[0].last);
        chk("words_done", words_done, exp_words[15:0]);
        if (fifo_out_ack === 1'b1) ack_cnt++;
        if (out_valid === 1'b1 && !s) beat_cnt++;
        if (r) begin
            exp_q.delete();
            exp_words = 0;
        end else begin
            if (m_acc) void'(exp_q.pop_front());
            if (m_drain && exp_words < 16'hFFFF) exp_words++;
            if (f) exp_q.delete();
            if (m_ack) begin
                w = fq.pop_front();
                for (int i = 0; i < KME_KEY_W / KME_BEAT_W; i++)
                    exp_q.push_back('{w[i*KME_BEAT_W +: KME_BEAT_W], i == 0, i == KME_KEY_W / KME_BEAT_W - 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2, 1'b0, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h3, 1'b0, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4, 1'b0, 1'b1, 16'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 16'd1};

        rst = 1'b1;
        flush = 1'b0;
        out_stall = 1'b0;
        fifo_out = '0;
        fifo_out_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then a single word with lanes 1..4, ack held off while rst is high.
        fq.push_back(mk_word(64'h1, 64'h2, 64'h3, 64'h4));
        for (int i = 0; i < 7; i++) begin
            tbl_cur = tbl[i];
            tbl_on = 1;
            cyc(tbl[i].r, tbl[i].f, tbl[i].s);
        end
        tbl_on = 0;

        // Streaming three words with no stall.
        ack_cnt = 0;
        beat_cnt = 0;
        for (int i = 0; i < 3; i++) fq.push_back(rnd_word());
        repeat (14) cyc(1'b0, 1'b0, 1'b0);
        chk("stream_acks", ack_cnt, 3);
        chk("stream_beats", beat_cnt, 12);
        chk("stream_words", words_done, 16'd4);

        // Backpressure on the second beat and on the last beat with the next word pending.
        fq.push_back(rnd_word());
        fq.push_back(rnd_word());
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        ack_cnt = 0;
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        chk("stall_last_no_ack", ack_cnt, 0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        chk("stall_words", words_done, 16'd6);

        // Flush on the second beat with the FIFO still holding a word.
        fq.push_back(rnd_word());
        fq.push_back(rnd_word());
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("flush_idle", out_valid, 1'b0);
        chk("flush_words", words_done, 16'd6);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        chk("flush_next_words", words_done, 16'd7);

        // Reset mid-word with the FIFO non-empty.
        fq.push_back(rnd_word());
        fq.push_back(rnd_word());
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_first", out_first, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_words", words_done, 16'd0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        chk("rst_next_words", words_done, 16'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (fq.size() < 4 && $urandom_range(0, 2) == 0) fq.push_back(rnd_word());
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
        end
        begin
            int budget;
            budget = 0;
            while ((fq.size() != 0 || exp_q.size() != 0) && budget < 60) begin
                cyc(1'b0, 1'b0, 1'b0);
                budget++;
            end
            chk("drain_timeout", (budget < 60), 1'b1);
        end

        // Saturation from a forced near-full count.
        force dut.words_done_q = 16'hFFFE;
        @(negedge clk);
        release dut.words_done_q;
        exp_words = 16'hFFFE;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) fq.push_back(rnd_word());
        repeat (14) cyc(1'b0, 1'b0, 1'b0);
        chk("sat_words", words_done, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
